// File: rtl/timer_field_writer.sv
// Periodic "HH:MM:SS[.F...F]" writer into the character RAM, with sequential fraction-digit
// extraction. Optional macro TIMER_LEADING_BLANK_EN blanks a leading zero in the hours tens digit.
`timescale 1ns/1ps

module timer_field_writer #(
    parameter int unsigned COLS          = 80,
    parameter int unsigned ADDR_W        = 13,
    parameter int unsigned ROW           = 0,
    parameter int unsigned COL           = 64,
    parameter int unsigned FRAC_DIGITS   = 5,
    parameter int unsigned FRAC_W        = 17,
    parameter int unsigned UPDATE_PERIOD = 800000
) (
    input  logic              clock50MHz,
    input  logic              resetn,
    input  logic              enable,
    input  logic              forceUpdate,
    input  logic [5:0]        hours,
    input  logic [5:0]        minutes,
    input  logic [5:0]        seconds,
    input  logic [FRAC_W-1:0] subSeconds,
    output logic              charRamWrEn,
    output logic [ADDR_W-1:0] charRamAddr,
    output logic [6:0]        charRamData,
    output logic              busy,
    output logic              frameDone
);

    localparam int unsigned LEN   = (FRAC_DIGITS == 0) ? 8 : 9 + FRAC_DIGITS;
    localparam int unsigned CNT_W = $clog2(UPDATE_PERIOD);
    localparam int unsigned FW1   = FRAC_W + 1;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(ROW * COLS + COL);
    localparam logic [2:0] K_INIT = 3'((FRAC_DIGITS > 0) ? FRAC_DIGITS - 1 : 0);

    function automatic logic [FW1-1:0] pow10(input int unsigned n);
        case (n)
            0:       return FW1'(1);
            1:       return FW1'(10);
            2:       return FW1'(100);
            3:       return FW1'(1000);
            4:       return FW1'(10000);
            default: return FW1'(100000);
        endcase
    endfunction

    localparam logic [FW1-1:0]    FRAC_LIMIT = pow10(FRAC_DIGITS);
    localparam logic [FRAC_W-1:0] FRAC_MAX   = FRAC_W'(FRAC_LIMIT - FW1'(1));

    // Compare ladder instead of a divider; v is at most 63.
    function automatic logic [7:0] split10(input logic [5:0] v);
        logic [3:0] t;
        logic [5:0] r;
        if (v >= 6'd60) begin
            t = 4'd6; r = v - 6'd60;
        end else if (v >= 6'd50) begin
            t = 4'd5; r = v - 6'd50;
        end else if (v >= 6'd40) begin
            t = 4'd4; r = v - 6'd40;
        end else if (v >= 6'd30) begin
            t = 4'd3; r = v - 6'd30;
        end else if (v >= 6'd20) begin
            t = 4'd2; r = v - 6'd20;
        end else if (v >= 6'd10) begin
            t = 4'd1; r = v - 6'd10;
        end else begin
            t = 4'd0; r = v;
        end
        return {t, 4'(r)};
    endfunction

    function automatic logic [6:0] ascii(input logic [3:0] d);
        return 7'd48 + {3'b000, d};
    endfunction

    typedef enum logic [2:0] {StIdle, StSnap, StConv, StWrite, StDone} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic [5:0]        hours_q, min_q, sec_q;
    logic [FRAC_W-1:0] rem_q, rem_sub;
    logic [2:0]        k_q;
    logic [3:0]        cur_q;
    logic [3:0]        frac_dig_q [8];
    logic [3:0]        idx_q, nxt_idx;
    logic [6:0]        nxt_char;
    logic [FW1-1:0]    p;
    logic              rem_ge, tick, trigger;
    logic [3:0]        h_t, h_o, m_t, m_o, s_t, s_o;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [6:0]        data_q;

    always_comb begin
        tick    = enable && (cnt_q == CNT_W'(UPDATE_PERIOD - 1));
        trigger = tick || forceUpdate;
        cnt_d   = (!enable || tick) ? '0 : cnt_q + 1'b1;

        p       = pow10(32'(k_q));
        rem_ge  = {1'b0, rem_q} >= p;
        rem_sub = rem_q - FRAC_W'(p);

        state_d = state_q;
        pend_d  = pend_q;
        unique case (state_q)
            StIdle:  if (trigger) state_d = StSnap;
            StSnap:  state_d = (FRAC_DIGITS == 0) ? StWrite : StConv;
            StConv:  if (!rem_ge && k_q == 3'd0) state_d = StWrite;
            StWrite: if (idx_q == 4'(LEN - 1)) state_d = StDone;
            StDone: begin
                if (pend_q || trigger) begin
                    state_d = StSnap;
                    pend_d  = 1'b0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (trigger && (state_q inside {StSnap, StConv, StWrite})) pend_d = 1'b1;

        {h_t, h_o} = split10(hours_q);
        {m_t, m_o} = split10(min_q);
        {s_t, s_o} = split10(sec_q);

        nxt_idx  = (state_q == StWrite) ? idx_q + 4'd1 : 4'd0;
        nxt_char = 7'd0;
        case (nxt_idx)
            4'd0: begin
                nxt_char = ascii(h_t);
`ifdef TIMER_LEADING_BLANK_EN
                if (h_t == 4'd0) nxt_char = 7'd32;
`endif
            end
            4'd1: nxt_char = ascii(h_o);
            4'd2: nxt_char = 7'd58;
            4'd3: nxt_char = ascii(m_t);
            4'd4: nxt_char = ascii(m_o);
            4'd5: nxt_char = 7'd58;
            4'd6: nxt_char = ascii(s_t);
            4'd7: nxt_char = ascii(s_o);
            4'd8: nxt_char = 7'd46;
            // Fraction character 9+j holds the digit stored at k = FRAC_DIGITS-1-j.
            default: nxt_char = ascii(frac_dig_q[3'(4'(FRAC_DIGITS + 8) - nxt_idx)]);
        endcase
    end

    always_ff @(posedge clock50MHz) begin
        if (!resetn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            hours_q <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            rem_q   <= '0;
            k_q     <= '0;
            cur_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            for (int i = 0; i < 8; i++) frac_dig_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;

            // Snapshot on the edge entering SNAP, so later input changes cannot tear the frame.
            if (state_d == StSnap) begin
                hours_q <= hours;
                min_q   <= (minutes > 6'd59) ? 6'd59 : minutes;
                sec_q   <= (seconds > 6'd59) ? 6'd59 : seconds;
                rem_q   <= ({1'b0, subSeconds} >= FRAC_LIMIT) ? FRAC_MAX : subSeconds;
                k_q     <= K_INIT;
                cur_q   <= '0;
            end

            if (state_q == StConv) begin
                if (rem_ge) begin
                    rem_q <= rem_sub;
                    cur_q <= cur_q + 4'd1;
                end else begin
                    frac_dig_q[k_q] <= cur_q;
                    cur_q           <= '0;
                    if (k_q != 3'd0) k_q <= k_q - 3'd1;
                end
            end

            if (state_d == StWrite) begin
                wr_q   <= 1'b1;
                idx_q  <= nxt_idx;
                addr_q <= BASE + ADDR_W'(nxt_idx);
                data_q <= nxt_char;
            end else begin
                wr_q <= 1'b0;
            end
        end
    end

    assign charRamWrEn = wr_q;
    assign charRamAddr = addr_q;
    assign charRamData = data_q;
    assign busy        = (state_q == StSnap) || (state_q == StConv) || (state_q == StWrite);
    assign frameDone   = (state_q == StDone);

endmodule

// File: tb/tb_timer_field_writer.sv
// Scoreboard bench: two writer instances (5 and 0 fraction digits) checked against a
// string-building reference model of the expected RAM writes and busy lengths.
`timescale 1ns/1ps

module tb_timer_field_writer;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic        resetn, enable, enable0, force1, force0;
    logic [5:0]  hours, minutes, seconds;
    logic [16:0] sub;
    logic        wr1, wr0, busy1, busy0, done1, done0;
    logic [12:0] addr1, addr0;
    logic [6:0]  data1, data0;

    timer_field_writer #(.UPDATE_PERIOD(100)) dut1 (
        .clock50MHz(clk), .resetn(resetn), .enable(enable), .forceUpdate(force1),
        .hours(hours), .minutes(minutes), .seconds(seconds), .subSeconds(sub),
        .charRamWrEn(wr1), .charRamAddr(addr1), .charRamData(data1),
        .busy(busy1), .frameDone(done1)
    );

    timer_field_writer #(.ROW(2), .COL(10), .FRAC_DIGITS(0), .UPDATE_PERIOD(100)) dut0 (
        .clock50MHz(clk), .resetn(resetn), .enable(enable0), .forceUpdate(force0),
        .hours(hours), .minutes(minutes), .seconds(seconds), .subSeconds(sub),
        .charRamWrEn(wr0), .charRamAddr(addr0), .charRamData(data0),
        .busy(busy0), .frameDone(done0)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int unsigned ew0[$], ew1[$];  // expected {addr, data} writes
    int unsigned eb0[$], eb1[$];  // expected busy length per frame
    int wcnt[2], run[2], bcnt[2];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Reference: build the expected character string from the clamped time values.
    function automatic void push_frame(int u, int h, int m, int s, int f);
        int fd   = (u == 1) ? 5 : 0;
        int base = (u == 1) ? 64 : 170;
        int lim  = 1;
        int conv = 0;
        int div, d;
        int ch[$];
        for (int i = 0; i < fd; i++) lim = lim * 10;
        if (m > 59) m = 59;
        if (s > 59) s = 59;
        if (f >= lim) f = lim - 1;
        ch.push_back(48 + h / 10);
`ifdef TIMER_LEADING_BLANK_EN
        if (h / 10 == 0) ch[0] = 32;
`endif
        ch.push_back(48 + h % 10);
        ch.push_back(58);
        ch.push_back(48 + m / 10);
        ch.push_back(48 + m % 10);
        ch.push_back(58);
        ch.push_back(48 + s / 10);
        ch.push_back(48 + s % 10);
        if (fd > 0) begin
            ch.push_back(46);
            div = lim;
            for (int j = 0; j < fd; j++) begin
                div = div / 10;
                d   = (f / div) % 10;
                ch.push_back(48 + d);
                conv += d + 1;
            end
        end
        for (int i = 0; i < ch.size(); i++) begin
            if (u == 1) ew1.push_back(unsigned'(((base + i) << 7) | ch[i]));
            else        ew0.push_back(unsigned'(((base + i) << 7) | ch[i]));
        end
        if (u == 1) eb1.push_back(unsigned'(ch.size() + conv + 1));
        else        eb0.push_back(unsigned'(ch.size() + 1));
    endfunction

    // Monitor: pops expected writes on every strobe, checks frame shape on frameDone.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            logic w, b, d;
            logic [12:0] a;
            logic [6:0] c;
            int unsigned e, bl;
            logic miss;
            w = (u == 1) ? wr1 : wr0;
            b = (u == 1) ? busy1 : busy0;
            d = (u == 1) ? done1 : done0;
            a = (u == 1) ? addr1 : addr0;
            c = (u == 1) ? data1 : data0;
            if (w === 1'b1) begin
                wcnt[u]++;
                run[u]++;
                miss = (u == 1) ? (ew1.size() == 0) : (ew0.size() == 0);
                if (miss) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected write u%0d: addr %0d data %0d, none expected", u, a, c);
                end else begin
                    e = (u == 1) ? ew1.pop_front() : ew0.pop_front();
                    check($sformatf("write addr u%0d", u), 32'(a), e >> 7);
                    check($sformatf("write data u%0d", u), 32'(c), e & 32'h7f);
                end
            end
            if (b === 1'b1) bcnt[u]++;
            if (d === 1'b1) begin
                miss = (u == 1) ? (eb1.size() == 0) : (eb0.size() == 0);
                bl = miss ? 0 : ((u == 1) ? eb1.pop_front() : eb0.pop_front());
                check($sformatf("frame writes u%0d", u), 32'(run[u]), (u == 1) ? 14 : 8);
                check($sformatf("busy length u%0d", u), 32'(bcnt[u]), bl);
                check($sformatf("busy low at frameDone u%0d", u), {31'b0, b}, 0);
                bcnt[u] = 0;
            end
            if (w !== 1'b1) run[u] = 0;
            if (!resetn) begin
                run[u]  = 0;
                bcnt[u] = 0;
            end
        end
    end

    function automatic logic done_of(int u);
        return (u == 1) ? done1 : done0;
    endfunction

    task automatic scramble();
        hours   = 6'($urandom);
        minutes = 6'($urandom);
        seconds = 6'($urandom);
        sub     = 17'($urandom);
    endtask

    // Called at a negedge; returns at the negedge of the first busy cycle.
    task automatic trig(input int u, input int h, input int m, input int s, input int f);
        hours   = 6'(h);
        minutes = 6'(m);
        seconds = 6'(s);
        sub     = 17'(f);
        push_frame(u, h, m, s, f);
        if (u == 1) force1 = 1'b1; else force0 = 1'b1;
        @(negedge clk);
        force1 = 1'b0;
        force0 = 1'b0;
    endtask

    task automatic wait_done(input int u, input int limit);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done_of(u) !== 1'b1 && n < limit);
        if (done_of(u) !== 1'b1) check($sformatf("frameDone timeout u%0d", u), 0, 1);
    endtask

    initial begin
        int n, k, w0, h, m, s, f, u;
        resetn = 1'b0; enable = 1'b0; enable0 = 1'b0; force1 = 1'b0; force0 = 1'b0;
        hours = '0; minutes = '0; seconds = '0; sub = '0;
        wcnt[0] = 0; wcnt[1] = 0; run[0] = 0; run[1] = 0; bcnt[0] = 0; bcnt[1] = 0;
        repeat (3) @(negedge clk);
        check("reset wrEn", {31'b0, wr1 | wr0}, 0);
        check("reset addr", {19'b0, addr1 | addr0}, 0);
        check("reset data", {25'b0, data1 | data0}, 0);
        check("reset busy", {31'b0, busy1 | busy0}, 0);
        check("reset frameDone", {31'b0, done1 | done0}, 0);
        resetn = 1'b1;
        @(negedge clk);

        // Periodic tick: 1/23/45/6789; inputs scrambled right after the snapshot.
        hours = 6'd1; minutes = 6'd23; seconds = 6'd45; sub = 17'd6789;
        push_frame(1, 1, 23, 45, 6789);
        enable = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy1 !== 1'b1 && n < 300);
        check("tick to busy cycles", 32'(n), 100);
        scramble();
        wait_done(1, 200);
        enable = 1'b0;
        @(negedge clk);

        // Clamping.
        trig(1, 9, 61, 63, 120000);
        wait_done(1, 200);
        @(negedge clk);

        // Three forces while busy give one extra frame, using inputs present at its snapshot.
        trig(1, 12, 34, 56, 78);
        hours = 6'd23; minutes = 6'd45; seconds = 6'd7; sub = 17'd99999;
        push_frame(1, 23, 45, 7, 99999);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            force1 = 1'b1;
            @(negedge clk);
            force1 = 1'b0;
            @(negedge clk);
        end
        wait_done(1, 200);
        @(negedge clk);
        check("pending frame starts after frameDone", {31'b0, busy1}, 1);
        scramble();
        wait_done(1, 200);

        // Disabled and no force: silence.
        w0 = wcnt[0] + wcnt[1];
        repeat (1000) @(negedge clk);
        check("no writes while disabled", 32'(wcnt[0] + wcnt[1]), 32'(w0));

        // Fixed FRAC_DIGITS=0 frame, then randomized frames on both instances.
        trig(0, 1, 23, 45, 0);
        wait_done(0, 100);
        @(negedge clk);
        for (int i = 0; i < 24; i++) begin
            u = i % 2;
            h = int'($urandom_range(0, 63));
            m = int'($urandom_range(0, 63));
            s = int'($urandom_range(0, 63));
            f = (i % 3 == 0) ? int'($urandom_range(99990, 131071)) : int'($urandom_range(0, 99999));
            trig(u, h, m, s, f);
            scramble();
            wait_done(u, 200);
            @(negedge clk);
        end

        // Reset during the 5th write aborts the frame.
        trig(1, 7, 8, 9, 12345);
        k = 0;
        n = 0;
        while (k < 5 && n < 200) begin
            @(negedge clk);
            n++;
            if (wr1 === 1'b1) k++;
        end
        check("reached 5th write", 32'(k), 5);
        resetn = 1'b0;
        @(negedge clk);
        check("wrEn low after reset", {31'b0, wr1}, 0);
        check("busy low after reset", {31'b0, busy1}, 0);
        check("frameDone low after reset", {31'b0, done1}, 0);
        ew1.delete();
        eb1.delete();
        @(negedge clk);
        resetn = 1'b1;
        w0 = wcnt[0] + wcnt[1];
        repeat (300) @(negedge clk);
        check("no writes after reset release", 32'(wcnt[0] + wcnt[1]), 32'(w0));
        check("scoreboard drained", 32'(ew0.size() + ew1.size() + eb0.size() + eb1.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/timer_field_writer.md
Name: timer_field_writer

Overview:
Parametrised successor to the fixed top-right timer writer. Periodically snapshots the clockCounter outputs and writes "HH:MM:SS[.F...F]" into the dual-port character RAM at a configurable row/column, with a configurable number of fractional digits. Fractional-digit extraction is sequential (repeated subtraction), so no wide combinational dividers are used. The block sits between clockCounter and characterRAM port A in the raycaster/text overlay top level.

Parameters:
COLS, 80, characters per text row
ADDR_W, 13, character RAM address width
ROW, 0, field row
COL, 64, field start column; base address = ROW*COLS+COL
FRAC_DIGITS, 5, fractional digits written, legal range 0..5
FRAC_W, 17, subSeconds width
UPDATE_PERIOD, 800000, clock cycles between automatic updates (minimum 2)

Ports:
clock50MHz  in  1  clock
resetn  in  1  synchronous active-low reset
enable  in  1  high allows automatic periodic updates
forceUpdate  in  1  single-cycle request for an immediate update
hours  in  6  0..63
minutes  in  6  0..59
seconds  in  6  0..59
subSeconds  in  FRAC_W  fractional count, 0..10^FRAC_DIGITS-1
charRamWrEn  out  1  write strobe
charRamAddr  out  ADDR_W  write address
charRamData  out  7  ASCII character
busy  out  1  high from trigger until the final write completes
frameDone  out  1  one-cycle pulse after the final write

Behaviour:
- Reset is sampled on clock50MHz. At reset, all outputs are 0, the state is IDLE, the period counter is 0 and the pending flag is cleared. A reset asserted mid-update aborts the update; charRamWrEn is 0 from the next edge.
- Field length L = 8 when FRAC_DIGITS=0, otherwise 9+FRAC_DIGITS. Character i goes to base+i, i = 0..L-1, written in ascending order.
- Period counter:
  - Counts 0..UPDATE_PERIOD-1 only while enable=1. When enable=0 it is held at 0.
  - The counter keeps counting while busy.
  - A tick (counter reaches UPDATE_PERIOD-1) or forceUpdate is a trigger.
- Trigger handling:
  - A trigger in IDLE starts an update.
  - A trigger while busy sets a one-deep pending flag. The next update starts the cycle after frameDone, and the flag clears at that point.
  - Multiple triggers while busy still produce only one extra update.
- Dropping enable mid-update does not abort the update in progress.
- States:
  - IDLE: waits for a trigger.
  - SNAP: on the trigger edge, latch all time inputs and assert busy. Any later input change does not affect this frame, so there is no tearing.
  - CONV: one subtract of 10^k per cycle from the latched fraction, k = FRAC_DIGITS-1 down to 0. Each digit takes (digit value + 1) cycles. Worst case is 10*FRAC_DIGITS cycles. CONV is skipped when FRAC_DIGITS=0.
  - WRITE: one character per cycle, charRamWrEn=1 for exactly L consecutive cycles. The cycle after the last write, charRamWrEn=0, busy=0 and frameDone=1 for one cycle. Return to IDLE, or go straight to SNAP if the pending flag is set.
- Clamping is applied at snapshot:
  - minutes and seconds > 59 become 59.
  - subSeconds >= 10^FRAC_DIGITS becomes 10^FRAC_DIGITS-1 (all '9').
  - hours is split into tens/ones by a 6-bit compare ladder, not a divider.
- ASCII encoding: digits are 48+d, ':' is 58, '.' is 46.
- Outside WRITE, charRamAddr and charRamData hold their last values.

Optional Feature:
TIMER_LEADING_BLANK_EN:
- When defined, a tens digit of 0 in the hours position is written as a space (ASCII 32). Minutes, seconds and fractional digits are never blanked.
- When undefined, the hours tens digit is always written as a digit, e.g. '0'.

Test Plan:
- Defaults with UPDATE_PERIOD=100 and enable=1; inputs 1/23/45/6789 -> at the first tick, 14 consecutive writes "01:23:45.06789" to addresses 64..77, then busy=0 and a frameDone pulse.
- Change the inputs on the cycle after the trigger -> the written field still reflects the snapshot values 1/23/45/6789.
- minutes=61, seconds=63, subSeconds=120000 -> writes "…:59:59.99999".
- FRAC_DIGITS=0, ROW=2, COL=10 -> exactly 8 writes "HH:MM:SS" at 170..177, no '.' and no CONV cycles.
- Pulse forceUpdate three times while busy -> exactly one extra frame, starting the cycle after frameDone; with enable=0 and no forceUpdate -> no writes for 1000 cycles.
- Assert resetn=0 during the 5th write -> charRamWrEn=0 the next cycle, busy=0, and after release no writes until the next trigger.
